lfsr_rng: RTL and testbench

Parametrised Fibonacci LFSR random-number source, the successor to the fixed 5-bit `fib_random_design` generator. Width, tap polynomial, reset seed and sample width are parameters. The block adds a runtime seed load with zero-lockup protection, an advance enable, a valid/ready output handshake that never drops or repeats bits, and a period-wrap flag. It feeds game/display logic that consumes random words on demand.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_core.sv | 36 +++
 rtl/lfsr_rng.sv | 143 ++++++++++++++
 tb/tb_lfsr_rng.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the Fibonacci LFSR random source.
// Holds the FSM encoding, maximal-length tap masks and the step function.
package lfsr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } lfsr_state_e;

  // Maximal-length feedback masks indexed by width; bit i feeds state[i] into the XOR.
  localparam logic [31:0] DEFAULT_TAPS [3:32] = '{
    32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
    32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
    32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
    32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
    32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
    32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
    32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
    32'h4800_0000, 32'h8020_0003
  };

  // Callers pass zero-extended operands and truncate the result to their width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
    logic fb;
    fb = ^(state & taps);
    return {state[30:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed mux and zero-seed substitution.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS[WIDTH]),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] next_s;

  assign next_s = WIDTH'(lfsr_step(32'(state_r), 32'(TAPS)));
  assign state  = state_r;

  // State register: a load beats an advance, and a zero load falls back to SEED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= (load_val == '0) ? SEED : load_val;
    end else if (adv) begin
      state_r <= next_s;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Random word source: LFSR core plus fill/hold handshake FSM, period-wrap flag
// and zero-seed lockup indication.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS[WIDTH]),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             wrap,
  output logic             lockup_fix
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_rng: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_rng: SEED must be non-zero");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $fatal(1, "lfsr_rng: OUT_W must be in 1..WIDTH");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $fatal(1, "lfsr_rng: TAPS must include the top state bit");
  end

  lfsr_state_e      fsm_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] ref_r;
  logic [WIDTH-1:0] state_s;
  logic [WIDTH-1:0] next_s;
  logic [OUT_W-1:0] out_data_r;
  logic             out_valid_r;
  logic             wrap_r;
  logic             lockup_fix_r;
  logic             adv_s;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv_s),
    .load     (seed_valid),
    .load_val (seed_in),
    .state    (state_s)
  );

  assign next_s = WIDTH'(lfsr_step(32'(state_s), 32'(TAPS)));

  // The LFSR only moves while filling, or on the edge that hands over a sample.
  always_comb begin
    adv_s = 1'b0;
    if (seed_valid) begin
      adv_s = 1'b0;
    end else if (fsm_r == FILL) begin
      adv_s = en;
    end else begin
      adv_s = en && out_valid_r && out_ready;
    end
  end

  // Fill/hold FSM with the sample register, period reference and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r        <= FILL;
      cnt_r        <= '0;
      ref_r        <= SEED;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      wrap_r       <= 1'b0;
      lockup_fix_r <= 1'b0;
    end else if (seed_valid) begin
      fsm_r        <= FILL;
      cnt_r        <= '0;
      ref_r        <= (seed_in == '0) ? SEED : seed_in;
      out_valid_r  <= 1'b0;
      wrap_r       <= 1'b0;
      lockup_fix_r <= (seed_in == '0);
    end else begin
      lockup_fix_r <= 1'b0;
      wrap_r       <= adv_s && (next_s == ref_r);
      case (fsm_r)
        FILL: begin
          if (en) begin
            if (cnt_r == CNT_W'(OUT_W - 1)) begin
              out_data_r  <= next_s[OUT_W-1:0];
              out_valid_r <= 1'b1;
              cnt_r       <= '0;
              fsm_r       <= HOLD;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1'b1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        HOLD: begin
          if (out_valid_r && out_ready) begin
            // Single-bit samples complete on the handover shift itself.
            if (en && (OUT_W == 1)) begin
              out_data_r <= next_s[OUT_W-1:0];
            end else if (en) begin
              out_valid_r <= 1'b0;
              cnt_r       <= CNT_W'(1'b1);
              fsm_r       <= FILL;
            end else begin
              out_valid_r <= 1'b0;
              cnt_r       <= '0;
              fsm_r       <= FILL;
            end
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          fsm_r       <= FILL;
          cnt_r       <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign wrap       = wrap_r;
  assign lockup_fix = lockup_fix_r;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: default 5-bit instance plus a 16-bit single-bit-sample instance.
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       rst_n, en, seed_valid, out_ready;
  logic [4:0] seed_in;
  logic       out_valid, wrap, lockup_fix;
  logic [4:0] out_data;

  logic        rst16_n, en16, ready16;
  logic [15:0] seed16;
  logic        valid16, wrap16, lock16;
  logic [0:0]  data16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_rng dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed_in(seed_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wrap(wrap), .lockup_fix(lockup_fix)
  );

  lfsr_rng #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(1)) dut16 (
    .clk(clk), .rst_n(rst16_n), .en(en16), .seed_valid(1'b0), .seed_in(seed16),
    .out_valid(valid16), .out_ready(ready16), .out_data(data16),
    .wrap(wrap16), .lockup_fix(lock16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  initial begin
    logic [4:0]  exp_m;
    logic [4:0]  d;
    logic        hs;
    logic [31:0] seen;
    int          bad, accepted, wcnt, last_w, nsamp, dup, wpos;

    rst_n = 1'b0; en = 1'b0; seed_valid = 1'b0; seed_in = 5'h00; out_ready = 1'b0;
    rst16_n = 1'b0; en16 = 1'b1; ready16 = 1'b1; seed16 = 16'h0000;
    tick(); tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_wrap", 32'(wrap), 32'd0);
    check("reset_lockup_fix", 32'(lockup_fix), 32'd0);

    // First sample: 01->02->04->09->12->05
    rst_n = 1'b1; en = 1'b1;
    repeat (4) tick();
    check("first_not_yet_valid", 32'(out_valid), 32'd0);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_data", 32'(out_data), 32'h05);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 5'h05) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);

    // Backpressure: accepted samples must follow the reference stream exactly.
    exp_m = 5'h05; accepted = 0;
    for (int cyc = 0; cyc < 400 && accepted < 12; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      hs = out_valid && out_ready;
      d  = out_data;
      tick();
      if (hs) begin
        check($sformatf("bp_sample_%0d", accepted), 32'(d), 32'(exp_m));
        for (int k = 0; k < 5; k++) exp_m = m_step(exp_m);
        accepted++;
      end
    end
    check("bp_accept_count", 32'(accepted), 32'd12);

    // Full period from reset with en and out_ready held high.
    out_ready = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0; wcnt = 0; last_w = -1; nsamp = 0; dup = 0; seen = 32'h0;
    for (int t = 1; t <= 160; t++) begin
      tick();
      if (wrap) begin
        if (last_w < 0 && t != 31) bad++;
        if (last_w >= 0 && t - last_w != 31) bad++;
        last_w = t;
        wcnt++;
      end
      if (out_valid && nsamp < 31) begin
        if (seen[out_data]) dup++;
        seen[out_data] = 1'b1;
        nsamp++;
      end
    end
    check("period_wrap_count", 32'(wcnt), 32'd5);
    check("period_wrap_spacing", 32'(bad), 32'd0);
    check("period_states_seen", seen, 32'hFFFF_FFFE);
    check("period_no_repeat", 32'(dup), 32'd0);

    // Zero seed falls back to SEED and flags it.
    en = 1'b0; out_ready = 1'b0; seed_valid = 1'b1; seed_in = 5'h00;
    tick();
    check("zero_seed_lockup_fix", 32'(lockup_fix), 32'd1);
    check("zero_seed_valid_drop", 32'(out_valid), 32'd0);
    check("zero_seed_no_wrap", 32'(wrap), 32'd0);
    seed_valid = 1'b0; en = 1'b1;
    tick();
    check("lockup_fix_one_cycle", 32'(lockup_fix), 32'd0);
    repeat (3) tick();
    check("zero_seed_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("zero_seed_sample_valid", 32'(out_valid), 32'd1);
    check("zero_seed_sample", 32'(out_data), 32'h05);

    // Seed 10 loaded over a pending sample; en gaps stretch the fill: 10->01->02->04->09->12
    seed_valid = 1'b1; seed_in = 5'h10;
    tick();
    check("load_hold_valid_drop", 32'(out_valid), 32'd0);
    check("load_hold_no_lockup", 32'(lockup_fix), 32'd0);
    seed_valid = 1'b0;
    tick(); tick();
    en = 1'b0;
    repeat (3) tick();
    check("en_low_no_sample", 32'(out_valid), 32'd0);
    en = 1'b1;
    tick(); tick();
    check("seed10_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("seed10_valid", 32'(out_valid), 32'd1);
    check("seed10_sample", 32'(out_data), 32'h12);

    // 16-bit, single-bit samples: valid stays high, wrap once per 65535 shifts.
    check("w16_reset_valid", 32'(valid16), 32'd0);
    rst16_n = 1'b1;
    bad = 0; wcnt = 0; wpos = 0;
    for (int t = 1; t <= 65540; t++) begin
      tick();
      if (t == 1) begin
        check("w16_first_valid", 32'(valid16), 32'd1);
        check("w16_first_bit", 32'(data16), 32'd0);
      end
      if (t == 11) check("w16_bit11", 32'(data16), 32'd1);
      if (valid16 !== 1'b1) bad++;
      if (wrap16) begin
        wcnt++;
        wpos = t;
      end
    end
    check("w16_valid_steady", 32'(bad), 32'd0);
    check("w16_wrap_count", 32'(wcnt), 32'd1);
    check("w16_wrap_position", 32'(wpos), 32'd65535);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
